// File: rtl/teller_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : teller_dispatcher
// Description : Sequences the bank-queue people counter and shares waiting
//               customers between up to three tellers. Arrival and call
//               strobes become serialized up/down counter strobes, tickets are
//               numbered, and free tellers are served in round-robin order.
// Revision    : 1.0 - initial release
// ============================================================================
module teller_dispatcher #(
    parameter int NUM_TELLERS = 3,
    parameter int CNT_W       = 4,
    parameter int MAX_Q       = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arrive,
    input  logic [NUM_TELLERS-1:0] teller_req,
    input  logic [NUM_TELLERS-1:0] teller_en,
    input  logic [CNT_W-1:0]       pcount,
    output logic                   cnt_up,
    output logic                   cnt_down,
    output logic [NUM_TELLERS-1:0] grant,
    output logic [CNT_W-1:0]       serve_ticket,
    output logic [CNT_W-1:0]       issue_ticket,
    output logic                   reject,
    output logic [1:0]             tcount,
    output logic                   busy
);

    localparam int                PTR_W     = 2;
    localparam int                HOLD_W    = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  MAX_Q_C   = CNT_W'(MAX_Q);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_TELLERS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALL = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_TELLERS-1:0] req_q;
    logic [NUM_TELLERS-1:0] pend_q, pend_d;
    logic                   arrive_pend_q, arrive_pend_d;
    logic [PTR_W-1:0]       rr_q, rr_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [NUM_TELLERS-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]       serve_q, serve_d;
    logic [CNT_W-1:0]       issue_q, issue_d;
    logic [1:0]             tcount_q, tcount_d;

    logic [NUM_TELLERS-1:0] rise;
    logic [NUM_TELLERS-1:0] elig;
    logic                   sel_found;
    logic [PTR_W-1:0]       sel_idx;

    assign rise = teller_req & ~req_q;
    // A pending request only counts while its station is still open.
    assign elig = pend_q & teller_en;

    // Round-robin search: first eligible teller starting at rr_q, wrapping.
    always_comb begin
        logic [PTR_W:0] idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = '0;
        for (int k = 0; k < NUM_TELLERS; k++) begin
            idx = {1'b0, rr_q} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(NUM_TELLERS)) begin
                idx = idx - (PTR_W+1)'(NUM_TELLERS);
            end
            if (!sel_found && elig[idx[PTR_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = idx[PTR_W-1:0];
            end
        end
    end

    // Count of open stations, saturating at 3.
    always_comb begin
        logic [2:0] sum;
        sum = '0;
        for (int i = 0; i < NUM_TELLERS; i++) begin
            sum = sum + 3'(teller_en[i]);
        end
        tcount_d = (sum > 3'd3) ? 2'd3 : sum[1:0];
    end

    // Next-state, datapath updates and counter strobes.
    always_comb begin
        state_d       = state_q;
        pend_d        = (pend_q | (rise & teller_en)) & teller_en;
        arrive_pend_d = arrive_pend_q ? 1'b1 : arrive;
        rr_d          = rr_q;
        hold_d        = hold_q;
        grant_d       = grant_q;
        serve_d       = serve_q;
        issue_d       = issue_q;
        cnt_up        = 1'b0;
        cnt_down      = 1'b0;
        reject        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Never call a customer who is not in the queue.
                if ((|elig) && (pcount != '0)) begin
                    state_d = S_CALL;
                end
            end
            S_CALL: begin
                if (sel_found) begin
                    cnt_down        = 1'b1;
                    grant_d         = '0;
                    grant_d[sel_idx] = 1'b1;
                    serve_d         = serve_q + CNT_W'(1);
                    pend_d[sel_idx] = 1'b0;
                    rr_d            = (sel_idx == PTR_LAST) ? '0 : sel_idx + PTR_W'(1);
                    hold_d          = '0;
                    state_d         = S_HOLD;
                end else begin
                    // Station closed between IDLE and CALL: nothing to serve.
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (((grant_q & teller_en) == '0) || (hold_q == HOLD_LAST)) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase

        // Arrivals yield to a decrement so the counter sees one strobe a cycle.
        if (arrive_pend_q && !cnt_down) begin
            arrive_pend_d = 1'b0;
            if (pcount < MAX_Q_C) begin
                cnt_up  = 1'b1;
                issue_d = issue_q + CNT_W'(1);
            end else begin
                reject = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            req_q         <= '0;
            pend_q        <= '0;
            arrive_pend_q <= 1'b0;
            rr_q          <= '0;
            hold_q        <= '0;
            grant_q       <= '0;
            serve_q       <= '0;
            issue_q       <= '0;
            tcount_q      <= '0;
        end else begin
            state_q       <= state_d;
            req_q         <= teller_req;
            pend_q        <= pend_d;
            arrive_pend_q <= arrive_pend_d;
            rr_q          <= rr_d;
            hold_q        <= hold_d;
            grant_q       <= grant_d;
            serve_q       <= serve_d;
            issue_q       <= issue_d;
            tcount_q      <= tcount_d;
        end
    end

    // A station closing mid-hold loses its grant without waiting for a clock.
    assign grant        = grant_q & teller_en;
    assign serve_ticket = serve_q;
    assign issue_ticket = issue_q;
    assign tcount       = tcount_q;
    assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire
